// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the fetch stage: word/address geometry, opcode field,
// FSM states and the {pc, word} queue entry.
package instruction_fetch_unit_pkg;

  localparam int WORD_SIZE   = 19;
  localparam int ADDR_W      = 10;
  localparam int OPC_HI      = 18;
  localparam int OPC_LO      = 14;
  localparam int OPC_W       = OPC_HI - OPC_LO + 1;
  localparam int QUEUE_DEPTH = 2;
  localparam int CNT_W       = 2;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = '0;
  localparam logic [OPC_W-1:0]  OP_HALT      = 5'b11111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [WORD_SIZE-1:0] word;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [OPC_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: control inputs, instruction-memory read port and decode valid/ready.
// master is the fetch unit's view, slave is the surrounding pipeline/memory view.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
();

  logic                 run;
  logic                 redirect_valid;
  logic [ADDR_W-1:0]    redirect_addr;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WORD_SIZE-1:0] mem_instruction;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [WORD_SIZE-1:0] instr_out;
  logic [ADDR_W-1:0]    instr_pc;
  logic                 halted;

  modport master (
    input  run, redirect_valid, redirect_addr, mem_instruction, instr_ready,
    output mem_rd_en, mem_addr, instr_valid, instr_out, instr_pc, halted
  );

  modport slave (
    output run, redirect_valid, redirect_addr, mem_instruction, instr_ready,
    input  mem_rd_en, mem_addr, instr_valid, instr_out, instr_pc, halted
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry {pc, word} FIFO: registered write, combinational head, 0-cycle read; flush empties it.
// A push into a full queue is taken only together with a pop in the same cycle.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             flush,
  input  logic             wr_en,
  input  fetch_entry_t     wr_data,
  input  logic             rd_en,
  output fetch_entry_t     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     slots [QUEUE_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CNT_W-1:0] cnt;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(QUEUE_DEPTH));
  assign count   = cnt;
  assign rd_data = slots[rd_ptr];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        slots[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      // At full the write slot is the head being popped, so overwriting it is safe.
      if (do_wr) begin
        slots[wr_ptr] <= wr_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency memory reads, queues words for decode;
// issue-to-valid is 2 cycles, and reads are only issued when the 2-entry queue has credit.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET_N,
  instruction_fetch_unit_if.master fif
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] infl_pc;
  logic              inflight;

  logic              issue;
  logic              enq;
  logic              deq;
  logic              halt_hit;
  logic              credit_ok;
  logic [CNT_W-1:0]  occ;

  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_wr;

  // Datapath: handshake, credit check, issue and response capture.
  always_comb begin
    deq  = !q_empty && !fif.redirect_valid && fif.instr_ready;
    // Occupancy net of this cycle's pop, so a steady ready=1 stream sustains one read per cycle.
    occ  = q_count - {{(CNT_W-1){1'b0}}, deq};
    credit_ok = inflight ? (occ == '0) : !(q_full && !deq);
    issue = (state == FETCH) && !fif.redirect_valid && credit_ok;
    // Words returning after a HALT has been queued are past the end of the program.
    enq  = inflight && !fif.redirect_valid && (state != HALTED);
    q_wr = '{pc: infl_pc, word: fif.mem_instruction};
    halt_hit = enq && is_halt(fif.mem_instruction[OPC_HI:OPC_LO]);
  end

  // Next state and next PC; a redirect overrides every other event.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;

    if (fif.redirect_valid) begin
      pc_nxt = fif.redirect_addr;
    end else if (issue) begin
      pc_nxt = pc + ADDR_W'(1);
    end

    case (state)
      IDLE: begin
        // A HALT captured from the last read issued before run dropped still halts.
        if (halt_hit) begin
          state_nxt = HALTED;
        end else if (fif.run) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (fif.redirect_valid) begin
          state_nxt = fif.run ? FETCH : IDLE;
        end else if (halt_hit) begin
          state_nxt = HALTED;
        end else if (!fif.run) begin
          state_nxt = IDLE;
        end
      end
      HALTED: begin
        if (fif.redirect_valid) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      inflight <= 1'b0;
      infl_pc  <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      // A redirect suppresses issue, which also kills any response still outstanding.
      inflight <= issue;
      if (issue) begin
        infl_pc <= pc;
      end
    end
  end

  fetch_queue u_queue (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .flush   (fif.redirect_valid),
    .wr_en   (enq),
    .wr_data (q_wr),
    .rd_en   (deq),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign fif.mem_rd_en   = issue;
  assign fif.mem_addr    = issue ? pc : '0;
  assign fif.instr_valid = !q_empty && !fif.redirect_valid;
  assign fif.instr_out   = q_head.word;
  assign fif.instr_pc    = q_head.pc;
  assign fif.halted      = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: models the 1-cycle instruction memory,
// logs issued addresses and delivered words, and checks them against hand-derived sequences.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  typedef struct {
    int                   cyc;
    logic [ADDR_W-1:0]    pc;
    logic [WORD_SIZE-1:0] word;
  } dlv_t;

  logic CLK = 1'b0;
  logic RESET_N;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   first_iss = -1;
  int   first_vld = -1;

  logic [WORD_SIZE-1:0] mem [1024];
  dlv_t                 got_q [$];
  logic [ADDR_W-1:0]    iss_q [$];

  instruction_fetch_unit_if ifc ();

  instruction_fetch_unit dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .fif     (ifc)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (ifc.mem_rd_en) ifc.mem_instruction <= mem[ifc.mem_addr];
  end

  always @(negedge CLK) begin
    if (ifc.mem_rd_en) begin
      iss_q.push_back(ifc.mem_addr);
      if (first_iss < 0) first_iss = cyc;
    end
    if (ifc.instr_valid && first_vld < 0) first_vld = cyc;
    if (ifc.instr_valid && ifc.instr_ready) got_q.push_back('{cyc, ifc.instr_pc, ifc.instr_out});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_dlv(input string tag, input int i, input int exp_pc, input int exp_word);
    chk({tag, "_seen"}, 32'(i < got_q.size()), 32'd1);
    if (i < got_q.size()) begin
      chk({tag, "_pc"}, 32'(got_q[i].pc), 32'(exp_pc));
      chk({tag, "_word"}, 32'(got_q[i].word), 32'(exp_word));
    end
  endtask

  task automatic chk_iss(input string tag, input int i, input int exp_addr);
    chk({tag, "_seen"}, 32'(i < iss_q.size()), 32'd1);
    if (i < iss_q.size()) chk(tag, 32'(iss_q[i]), 32'(exp_addr));
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(ifc.mem_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(ifc.mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(ifc.instr_valid), 32'd0);
    chk({tag, "_out"}, 32'(ifc.instr_out), 32'd0);
    chk({tag, "_pc"}, 32'(ifc.instr_pc), 32'd0);
    chk({tag, "_halted"}, 32'(ifc.halted), 32'd0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    iss_q.delete();
  endtask

  task automatic redirect_to(input logic [ADDR_W-1:0] addr);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_addr  = addr;
    clear_logs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 19'(i + 100);
    RESET_N            = 1'b0;
    ifc.run            = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_addr  = '0;
    ifc.instr_ready    = 1'b1;

    // Reset state
    step(3);
    settle();
    chk_outs_zero("rst");

    // 1: stream from reset
    step(1);
    RESET_N = 1'b1;
    ifc.run = 1'b1;
    clear_logs();
    first_iss = -1;
    first_vld = -1;
    step(6);
    chk("t1_latency", 32'(first_vld - first_iss), 32'd2);
    chk_iss("t1_iss0", 0, 0);
    chk_iss("t1_iss1", 1, 1);
    chk_iss("t1_iss2", 2, 2);
    chk_dlv("t1_d0", 0, 0, 100);
    chk_dlv("t1_d1", 1, 1, 101);
    chk_dlv("t1_d2", 2, 2, 102);
    if (got_q.size() >= 3) begin
      chk("t1_b2b_1", 32'(got_q[1].cyc - got_q[0].cyc), 32'd1);
      chk("t1_b2b_2", 32'(got_q[2].cyc - got_q[1].cyc), 32'd1);
    end

    // 2: decode stall for 6 cycles
    ifc.instr_ready = 1'b0;
    step(5);
    settle();
    chk("t2_rd_en_sat", 32'(ifc.mem_rd_en), 32'd0);
    chk("t2_valid_hold", 32'(ifc.instr_valid), 32'd1);
    chk("t2_pc_hold", 32'(ifc.instr_pc), 32'd3);
    chk("t2_out_hold", 32'(ifc.instr_out), 32'd103);
    chk("t2_issued", 32'(iss_q.size()), 32'd5);
    chk("t2_occupancy", 32'(iss_q.size() - got_q.size()), 32'd2);
    step(1);
    ifc.instr_ready = 1'b1;
    step(12);
    for (int i = 0; i < 14; i++) chk_dlv($sformatf("t2_d%0d", i), i, i, i + 100);

    // 3: redirect with a queued word and a read in flight
    ifc.instr_ready = 1'b0;
    redirect_to(10'h200);
    settle();
    chk("t3_valid_masked", 32'(ifc.instr_valid), 32'd0);
    chk("t3_no_issue", 32'(ifc.mem_rd_en), 32'd0);
    step(1);
    ifc.redirect_valid = 1'b0;
    ifc.instr_ready    = 1'b1;
    settle();
    chk("t3_rd_en", 32'(ifc.mem_rd_en), 32'd1);
    chk("t3_addr", 32'(ifc.mem_addr), 32'h200);
    step(5);
    chk_dlv("t3_d0", 0, 'h200, 'h264);
    chk_dlv("t3_d1", 1, 'h201, 'h265);

    // 4: redirect while idle, then run across the address wrap
    ifc.run = 1'b0;
    step(4);
    redirect_to(10'd1022);
    step(1);
    ifc.redirect_valid = 1'b0;
    step(3);
    chk("t4_idle_no_issue", 32'(iss_q.size()), 32'd0);
    chk("t4_idle_no_dlv", 32'(got_q.size()), 32'd0);
    ifc.run = 1'b1;
    step(8);
    chk_iss("t4_iss0", 0, 1022);
    chk_dlv("t4_d0", 0, 1022, 1122);
    chk_dlv("t4_d1", 1, 1023, 1123);
    chk_dlv("t4_d2", 2, 0, 100);
    chk_dlv("t4_d3", 3, 1, 101);

    // 5: HALT at address 4, then redirect out of HALTED
    mem[4] = 19'h7C004;
    redirect_to(10'd0);
    step(1);
    ifc.redirect_valid = 1'b0;
    step(12);
    settle();
    chk("t5_halted", 32'(ifc.halted), 32'd1);
    chk("t5_rd_en", 32'(ifc.mem_rd_en), 32'd0);
    chk("t5_valid", 32'(ifc.instr_valid), 32'd0);
    chk("t5_issued", 32'(iss_q.size()), 32'd6);
    chk_iss("t5_last_iss", 5, 5);
    chk("t5_delivered", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 4; i++) chk_dlv($sformatf("t5_d%0d", i), i, i, i + 100);
    chk_dlv("t5_d4", 4, 4, 'h7C004);
    step(1);
    redirect_to(10'd0);
    step(1);
    ifc.redirect_valid = 1'b0;
    mem[4] = 19'd104;
    settle();
    chk("t5_unhalted", 32'(ifc.halted), 32'd0);
    chk("t5_resume_rd_en", 32'(ifc.mem_rd_en), 32'd1);
    chk("t5_resume_addr", 32'(ifc.mem_addr), 32'd0);

    // 6: asynchronous reset mid-stream
    step(6);
    settle();
    chk("t6_pre_valid", 32'(ifc.instr_valid), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk_outs_zero("t6_rst");
    step(2);
    clear_logs();
    RESET_N = 1'b1;
    step(6);
    chk_iss("t6_iss0", 0, 0);
    chk_dlv("t6_d0", 0, 0, 100);
    chk_dlv("t6_d1", 1, 1, 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
